// File: rtl/pmod_mic_adc_emulator.sv
// PmodMIC serial-ADC responder. A 12-bit sample from the fabric is shifted out
// on sdata, MSB first, behind LEAD_ZEROS zero bits. The external reader drives
// sclock and ncs. Both pins are oversampled on the fast system clock and are
// never used as clocks.
`timescale 1ns/1ps
module pmod_mic_adc_emulator #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sclock,
  input  logic                 ncs,
  output logic                 sdata,
  output logic                 sdata_oe,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 underrun
);

  localparam int FRAME = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ncs_sync;
  logic                   r_sclk_dly, r_ncs_dly;
  logic [DATA_BITS-1:0]   r_hold, r_last;
  logic                   r_hold_valid;
  logic [FRAME-1:0]       r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_sdata, r_sdata_oe;
  logic                   r_frame_done, r_frame_abort, r_underrun;

  logic                   w_sclk_fall, w_ncs_fall, w_ncs_rise;
  logic                   w_accept;
  logic                   w_start, w_shift, w_done, w_abort, w_end;
  logic [DATA_BITS-1:0]   w_s;
  logic [FRAME-1:0]       w_frame;

  // Synchronize sclock/ncs and keep one extra delayed copy for edge compare.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '1;
      r_ncs_sync  <= '1;
      r_sclk_dly  <= 1'b1;
      r_ncs_dly   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclock};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_dly  <= r_sclk_sync[SYNC_STAGES-1];
      r_ncs_dly   <= r_ncs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_fall = r_sclk_dly & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_fall  = r_ncs_dly  & ~r_ncs_sync[SYNC_STAGES-1];
  assign w_ncs_rise  = ~r_ncs_dly &  r_ncs_sync[SYNC_STAGES-1];

  assign w_accept = sample_valid & ~r_hold_valid;
  // A pending sample wins; otherwise a sample offered in the start cycle
  // bypasses the holding register; otherwise the last value is repeated.
  assign w_s      = r_hold_valid ? r_hold : (w_accept ? sample_data : r_last);
  assign w_frame  = {{LEAD_ZEROS{1'b0}}, w_s};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and per-cycle action strobes; an ncs rise beats an sclock fall.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == CNT_W'(FRAME - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_TAIL;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (w_ncs_rise) begin
          w_end       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, shift datapath, pad drive and status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold        <= '0;
      r_hold_valid  <= 1'b0;
      r_last        <= '0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_sdata       <= 1'b0;
      r_sdata_oe    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_underrun    <= 1'b0;

      if (w_start) begin
        if (r_hold_valid) begin
          r_hold       <= '0;
          r_hold_valid <= 1'b0;
        end
        r_shift    <= w_frame;
        r_last     <= w_s;
        r_bit_cnt  <= '0;
        r_sdata    <= w_frame[FRAME-1];
        r_sdata_oe <= 1'b1;
        r_underrun <= ~r_hold_valid & ~w_accept;
      end else if (w_accept) begin
        r_hold       <= sample_data;
        r_hold_valid <= 1'b1;
      end

      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= r_shift << 1;
        r_sdata   <= r_shift[FRAME-2];
      end

      if (w_done) begin
        r_bit_cnt    <= r_bit_cnt + 1'b1;
        r_sdata      <= 1'b0;
        r_frame_done <= 1'b1;
      end

      if (w_abort) begin
        r_sdata       <= 1'b0;
        r_sdata_oe    <= 1'b0;
        r_frame_abort <= 1'b1;
      end

      if (w_end) r_sdata_oe <= 1'b0;
    end
  end

  assign sdata        = r_sdata;
  assign sdata_oe     = r_sdata_oe;
  assign sample_ready = ~r_hold_valid;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = r_frame_done;
  assign frame_abort  = r_frame_abort;
  assign underrun     = r_underrun;

endmodule
